// File: rtl/lane_deskew_buffer_if.sv
// Lane bus between the deskew controller / lane receivers and the deskew
// buffer, plus the aligned outputs toward the descrambler.
interface lane_deskew_buffer_if #(
  parameter int LANE_COUNT  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int DELAY_WIDTH = 3
);
  logic [LANE_COUNT-1:0][DATA_WIDTH-1:0]  skewed_RX_Data;
  logic [LANE_COUNT-1:0]                  skewed_block_type;
  logic [LANE_COUNT-1:0]                  skewed_valid;
  logic [LANE_COUNT-1:0][DELAY_WIDTH-1:0] delay_select;
  logic [LANE_COUNT-1:0]                  valid_data;
  logic                                   valid_deskew;
  logic                                   Deskew_error;
  logic [LANE_COUNT-1:0][DATA_WIDTH-1:0]  deskewed_RX_Data;
  logic [LANE_COUNT-1:0]                  deskewed_block_type;
  logic [LANE_COUNT-1:0]                  deskewed_valid;
  logic                                   deskew_locked;
  logic                                   deskew_fail;

  modport master (
    output skewed_RX_Data, skewed_block_type, skewed_valid,
    output delay_select, valid_data, valid_deskew, Deskew_error,
    input  deskewed_RX_Data, deskewed_block_type, deskewed_valid,
    input  deskew_locked, deskew_fail
  );

  modport slave (
    input  skewed_RX_Data, skewed_block_type, skewed_valid,
    input  delay_select, valid_data, valid_deskew, Deskew_error,
    output deskewed_RX_Data, deskewed_block_type, deskewed_valid,
    output deskew_locked, deskew_fail
  );
endinterface

// File: rtl/lane_deskew_buffer.sv
// Per-lane programmable delay line. Each lane's symbol stream is delayed by
// 1..DEPTH cycles so all lanes present SDS-aligned symbols on the same edge.
module lane_deskew_buffer #(
  parameter int LANE_COUNT  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int DELAY_WIDTH = 3
) (
  input  logic                 RX_CLK,
  input  logic                 rst,
  input  logic                 Soft_RST_blocks,
  input  logic                 EN_LTSSM,
  lane_deskew_buffer_if.slave  lane_bus
);
  localparam int DEPTH = 2 ** DELAY_WIDTH;
  // The output register is the last stage, so the shift line holds DEPTH-1.
  localparam int SR_N  = DEPTH - 1;
  localparam int ENT_W = DATA_WIDTH + 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_TRAIN  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_ERROR  = 2'd3;

  logic [1:0]                                state;
  logic [1:0]                                state_nxt;
  logic [LANE_COUNT-1:0][DELAY_WIDTH-1:0]    locked_delay;
  logic [LANE_COUNT-1:0][SR_N-1:0][ENT_W-1:0] line_p0;
  logic [LANE_COUNT-1:0][ENT_W-1:0]          in_ent;
  logic [LANE_COUNT-1:0][ENT_W-1:0]          tap;
  logic [LANE_COUNT-1:0][DELAY_WIDTH-1:0]    tap_sel;
  logic [LANE_COUNT-1:0]                     vld_nxt;
  logic [LANE_COUNT-1:0][DATA_WIDTH-1:0]     data_p1;
  logic [LANE_COUNT-1:0]                     bt_p1;
  logic [LANE_COUNT-1:0]                     vld_p1;

  // Tap selection per lane and the valid qualification rule of each state.
  always_comb begin
    in_ent  = '0;
    tap_sel = '0;
    tap     = '0;
    vld_nxt = '0;
    for (int i = 0; i < LANE_COUNT; i++) begin
      in_ent[i] = {lane_bus.skewed_RX_Data[i], lane_bus.skewed_block_type[i],
                   lane_bus.skewed_valid[i]};
      case (state)
        ST_TRAIN:  tap_sel[i] = lane_bus.delay_select[i];
        ST_LOCKED: tap_sel[i] = locked_delay[i];
        default:   tap_sel[i] = '0;
      endcase
      tap[i] = (tap_sel[i] == '0) ? in_ent[i]
                                  : line_p0[i][tap_sel[i] - DELAY_WIDTH'(1)];
      // In TRAIN the controller's valid_data hides the symbol repeated when a
      // delay steps up; once locked the tap valid is trusted as-is.
      case (state)
        ST_TRAIN: vld_nxt[i] = tap[i][0] & lane_bus.valid_data[i];
        ST_ERROR: vld_nxt[i] = 1'b0;
        default:  vld_nxt[i] = tap[i][0];
      endcase
    end
  end

  // Next-state logic; EN_LTSSM low dominates error and lock requests.
  always_comb begin
    state_nxt = state;
    if (!EN_LTSSM) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_TRAIN;
        ST_TRAIN: begin
          if (lane_bus.Deskew_error)      state_nxt = ST_ERROR;
          else if (lane_bus.valid_deskew) state_nxt = ST_LOCKED;
        end
        ST_LOCKED: if (lane_bus.Deskew_error) state_nxt = ST_ERROR;
        default:   state_nxt = state;
      endcase
    end
  end

  // Control state and frozen per-lane delays.
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      locked_delay <= '0;
    end else if (Soft_RST_blocks) begin
      state        <= EN_LTSSM ? ST_TRAIN : ST_IDLE;
      locked_delay <= '0;
    end else begin
      state <= state_nxt;
      if (!EN_LTSSM)
        locked_delay <= '0;
      else if (state == ST_TRAIN && !lane_bus.Deskew_error && lane_bus.valid_deskew)
        locked_delay <= lane_bus.delay_select;
    end
  end

  // Shift lines (stage p0) and the output register (stage p1).
  always_ff @(posedge RX_CLK or negedge rst) begin
    if (!rst) begin
      line_p0 <= '0;
      data_p1 <= '0;
      bt_p1   <= '0;
      vld_p1  <= '0;
    end else if (Soft_RST_blocks) begin
      line_p0 <= '0;
      data_p1 <= '0;
      bt_p1   <= '0;
      vld_p1  <= '0;
    end else begin
      for (int i = 0; i < LANE_COUNT; i++) begin
        // stage p0: raw symbol enters the line
        line_p0[i][0] <= in_ent[i];
        for (int k = 1; k < SR_N; k++)
          line_p0[i][k] <= line_p0[i][k-1];
        // stage p1: selected tap registered toward the descrambler
        data_p1[i] <= tap[i][ENT_W-1:2];
        bt_p1[i]   <= tap[i][1];
        vld_p1[i]  <= vld_nxt[i];
      end
    end
  end

  assign lane_bus.deskewed_RX_Data    = data_p1;
  assign lane_bus.deskewed_block_type = bt_p1;
  assign lane_bus.deskewed_valid      = vld_p1;
  assign lane_bus.deskew_locked       = (state == ST_LOCKED);
  assign lane_bus.deskew_fail         = (state == ST_ERROR);
endmodule

// File: tb/tb_lane_deskew_buffer.sv
// Bench for lane_deskew_buffer: a history-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_lane_deskew_buffer;
  localparam int LN = 32, DW = 8, DLW = 3, MAXC = 4096;
  localparam int M_IDLE = 0, M_TRAIN = 1, M_LOCKED = 2, M_ERROR = 3;

  logic RX_CLK = 1'b0;
  logic rst, Soft_RST_blocks, EN_LTSSM;
  int   n_checks = 0, n_pass = 0;

  lane_deskew_buffer_if #(.LANE_COUNT(LN), .DATA_WIDTH(DW), .DELAY_WIDTH(DLW)) bus();

  lane_deskew_buffer #(.LANE_COUNT(LN), .DATA_WIDTH(DW), .DELAY_WIDTH(DLW)) dut (
    .RX_CLK(RX_CLK), .rst(rst), .Soft_RST_blocks(Soft_RST_blocks),
    .EN_LTSSM(EN_LTSSM), .lane_bus(bus)
  );

  always #5 RX_CLK = ~RX_CLK;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // ---------------- reference model ----------------
  // Output after edge c with delay d is the symbol presented at edge c-d,
  // or zero if that symbol predates the last flush.
  logic [DW+1:0]  hist [MAXC][LN];
  logic [DW+1:0]  ex   [LN];
  logic [DLW-1:0] lk   [LN];
  logic [DW+1:0]  got;
  logic           ex_locked, ex_fail;
  int cyc = 0, flush_c = -1, mode = M_IDLE, md, src;

  initial begin
    for (int i = 0; i < LN; i++) lk[i] = '0;
    forever begin
      @(posedge RX_CLK);
      for (int i = 0; i < LN; i++)
        hist[cyc % MAXC][i] = {bus.skewed_RX_Data[i], bus.skewed_block_type[i], bus.skewed_valid[i]};
      if (!rst || Soft_RST_blocks) begin
        for (int i = 0; i < LN; i++) begin ex[i] = '0; lk[i] = '0; end
        flush_c = cyc;
        mode = (rst && EN_LTSSM) ? M_TRAIN : M_IDLE;
      end else begin
        for (int i = 0; i < LN; i++) begin
          md = (mode == M_TRAIN) ? int'(bus.delay_select[i]) :
               (mode == M_LOCKED) ? int'(lk[i]) : 0;
          src = cyc - md;
          ex[i] = (src > flush_c) ? hist[src % MAXC][i] : '0;
          if (mode == M_TRAIN) ex[i][0] = ex[i][0] & bus.valid_data[i];
          if (mode == M_ERROR) ex[i][0] = 1'b0;
        end
        if (!EN_LTSSM) begin
          mode = M_IDLE;
          for (int i = 0; i < LN; i++) lk[i] = '0;
        end else if (mode == M_IDLE) begin
          mode = M_TRAIN;
        end else if (mode == M_TRAIN) begin
          if (bus.Deskew_error) mode = M_ERROR;
          else if (bus.valid_deskew) begin
            for (int i = 0; i < LN; i++) lk[i] = bus.delay_select[i];
            mode = M_LOCKED;
          end
        end else if (mode == M_LOCKED && bus.Deskew_error) begin
          mode = M_ERROR;
        end
      end
      ex_locked = (mode == M_LOCKED);
      ex_fail   = (mode == M_ERROR);
      cyc++;
      #1;
      for (int i = 0; i < LN; i++) begin
        got = {bus.deskewed_RX_Data[i], bus.deskewed_block_type[i], bus.deskewed_valid[i]};
        n_checks++;
        if (got === ex[i]) n_pass++;
        else $display("FAIL model lane%0d cyc%0d: got %0h expected %0h", i, cyc, got, ex[i]);
      end
      check("model_locked", 256'(bus.deskew_locked), 256'(ex_locked));
      check("model_fail",   256'(bus.deskew_fail),   256'(ex_fail));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge RX_CLK);
  endtask

  task automatic drive(input int lane, input logic [7:0] v);
    bus.skewed_RX_Data[lane]    = v;
    bus.skewed_block_type[lane] = v[7];
    bus.skewed_valid[lane]      = 1'b1;
  endtask

  task automatic drive_all(input logic [7:0] v);
    for (int i = 0; i < LN; i++) drive(i, v);
  endtask

  initial begin
    rst = 1'b0; Soft_RST_blocks = 1'b0; EN_LTSSM = 1'b0;
    bus.skewed_RX_Data = '0; bus.skewed_block_type = '0; bus.skewed_valid = '0;
    bus.delay_select = '0; bus.valid_data = '1;
    bus.valid_deskew = 1'b0; bus.Deskew_error = 1'b0;
    step(); step();
    check("reset_data",   256'(bus.deskewed_RX_Data), 256'd0);
    check("reset_valid",  256'(bus.deskewed_valid), 256'd0);
    check("reset_locked", 256'(bus.deskew_locked), 256'd0);
    check("reset_fail",   256'(bus.deskew_fail), 256'd0);
    rst = 1'b1;

    // Bypass in IDLE: one cycle latency
    drive(0, 8'h11); step(); check("bypass_11", 256'(bus.deskewed_RX_Data[0]), 256'h11);
    drive(0, 8'h22); step(); check("bypass_22", 256'(bus.deskewed_RX_Data[0]), 256'h22);
    drive(0, 8'h33); step(); check("bypass_33", 256'(bus.deskewed_RX_Data[0]), 256'h33);
    check("bypass_locked", 256'(bus.deskew_locked), 256'd0);

    // Alignment: SDS on lane0 at k=0, lane1 at k=3, others at k=5
    EN_LTSSM = 1'b1; drive_all(8'h01); step();
    bus.delay_select[0] = 3'd5; bus.delay_select[1] = 3'd2;
    bus.valid_data[3] = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      drive(0, (k == 0) ? 8'hE1 : 8'(8'h40 + k));
      drive(1, (k == 3) ? 8'hE1 : 8'(8'h50 + k));
      for (int i = 2; i < LN; i++) drive(i, (k == 5) ? 8'hE1 : 8'(8'h60 + k));
      bus.valid_deskew = (k == 5);
      step();
    end
    bus.valid_deskew = 1'b0;
    check("align_all_e1", 256'(bus.deskewed_RX_Data), {LN{8'hE1}});
    check("align_locked", 256'(bus.deskew_locked), 256'd1);

    // Lock freeze: delay_select changes ignored, lane0 keeps latency 6
    bus.delay_select[0] = 3'd7;
    drive_all(8'h77); step();
    for (int j = 1; j <= 5; j++) begin drive_all(8'(8'h10 + j)); step(); end
    check("freeze_data",  256'(bus.deskewed_RX_Data[0]), 256'h77);
    check("freeze_valid", 256'(bus.deskewed_valid[0]), 256'd1);

    // Soft reset mid-LOCKED with lines full of 0xAA
    drive_all(8'hAA);
    for (int j = 0; j < 8; j++) step();
    check("full_aa", 256'(bus.deskewed_RX_Data[0]), 256'hAA);
    Soft_RST_blocks = 1'b1; step();
    check("soft_data",   256'(bus.deskewed_RX_Data), 256'd0);
    check("soft_valid",  256'(bus.deskewed_valid), 256'd0);
    check("soft_locked", 256'(bus.deskew_locked), 256'd0);
    Soft_RST_blocks = 1'b0; bus.delay_select = '0;
    drive_all(8'h5A); step();
    check("soft_restart", 256'(bus.deskewed_RX_Data[0]), 256'h5A);
    check("soft_restart_v", 256'(bus.deskewed_valid[0]), 256'd1);

    // Error in TRAIN
    bus.Deskew_error = 1'b1; drive_all(8'h21); step();
    check("err_fail", 256'(bus.deskew_fail), 256'd1);
    bus.Deskew_error = 1'b0; drive_all(8'h22); step();
    check("err_valid0", 256'(bus.deskewed_valid), 256'd0);
    check("err_data_d0", 256'(bus.deskewed_RX_Data[5]), 256'h22);
    Soft_RST_blocks = 1'b1; step();
    check("err_cleared", 256'(bus.deskew_fail), 256'd0);
    Soft_RST_blocks = 1'b0; drive_all(8'h23); step();
    check("err_train_v", 256'(bus.deskewed_valid[0]), 256'd1);

    // Priority: error wins over valid_deskew
    bus.Deskew_error = 1'b1; bus.valid_deskew = 1'b1; step();
    bus.Deskew_error = 1'b0; bus.valid_deskew = 1'b0;
    check("prio_fail",   256'(bus.deskew_fail), 256'd1);
    check("prio_locked", 256'(bus.deskew_locked), 256'd0);
    EN_LTSSM = 1'b0; step();
    check("en_low_fail", 256'(bus.deskew_fail), 256'd0);
    EN_LTSSM = 1'b1; step();
    bus.valid_deskew = 1'b1; step(); bus.valid_deskew = 1'b0;
    check("relock", 256'(bus.deskew_locked), 256'd1);
    drive_all(8'h3C); step(); step();
    check("pre_rst_data", 256'(bus.deskewed_RX_Data[0]), 256'h3C);

    // Asynchronous reset mid-lock: outputs clear before any clock edge
    #2 rst = 1'b0;
    #1;
    check("arst_data",   256'(bus.deskewed_RX_Data), 256'd0);
    check("arst_valid",  256'(bus.deskewed_valid), 256'd0);
    check("arst_locked", 256'(bus.deskew_locked), 256'd0);
    step(); rst = 1'b1;
    drive(0, 8'h99); step();
    check("post_rst", 256'(bus.deskewed_RX_Data[0]), 256'h99);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, time %0t limit 100000", $time);
    $fatal(1);
  end
endmodule

// File: doc/lane_deskew_buffer.md
Name: lane_deskew_buffer

Overview:
- Per-lane programmable delay line directly downstream of the lane-to-lane deskew controller.
- Consumes the controller's per-lane delay_select, valid_data, valid_deskew and Deskew_error.
- Delays each lane's skewed symbol stream so that all lanes present SDS-aligned symbols on the same RX_CLK edge.
- Feeds aligned data, block type and valid to the descrambler/block-alignment stage.

Parameters:
LANE_COUNT, 32, number of lanes
DATA_WIDTH, 8, symbol width per lane
DELAY_WIDTH, 3, delay_select width; line depth DEPTH = 2**DELAY_WIDTH (8 stages)

Ports:
RX_CLK  input  1  receive clock
rst  input  1  asynchronous, active-low reset
Soft_RST_blocks  input  1  synchronous soft reset; flushes lines and state
EN_LTSSM  input  1  deskew enable from LTSSM
skewed_RX_Data  input  [DATA_WIDTH-1:0] x LANE_COUNT  unaligned lane symbols
skewed_block_type  input  LANE_COUNT  per-lane block-type flag accompanying the symbol
skewed_valid  input  LANE_COUNT  per-lane symbol valid
delay_select  input  [DELAY_WIDTH-1:0] x LANE_COUNT  live per-lane delay from the controller
valid_data  input  LANE_COUNT  per-lane data-valid qualifier from the controller
valid_deskew  input  1  controller reports all lanes aligned
Deskew_error  input  1  controller reports skew beyond limit
deskewed_RX_Data  output  [DATA_WIDTH-1:0] x LANE_COUNT  aligned symbols
deskewed_block_type  output  LANE_COUNT  aligned block-type flags
deskewed_valid  output  LANE_COUNT  aligned valid
deskew_locked  output  1  delays frozen, alignment in force
deskew_fail  output  1  sticky error until soft reset or EN_LTSSM low

Behaviour:
- Reset (rst low, async): all shift stages, outputs and locked delays = 0; state = IDLE; deskew_locked = 0; deskew_fail = 0.
- Per-lane line:
  - Stage sr[0] <= {data, block_type, valid} every cycle; sr[k] <= sr[k-1].
  - Tap select d: IDLE forces d=0; TRAIN uses live delay_select[i]; LOCKED uses the frozen locked_delay[i].
  - Output register <= (d==0) ? current input : sr[d-1]. Latency = 1+d cycles, range 1..DEPTH.
- States:
  - IDLE: EN_LTSSM=0. Bypass with d=0. deskewed_valid = registered skewed_valid. Go to TRAIN when EN_LTSSM=1.
  - TRAIN:
    - deskewed_valid[i] <= tap_valid & valid_data[i]. This masks the repeated symbol produced when delay_select increments.
    - If Deskew_error=1, go to ERROR.
    - Else if valid_deskew=1, then on the same edge: locked_delay[i] <= delay_select[i] for all lanes, go to LOCKED, set deskew_locked=1 on that edge.
  - LOCKED:
    - Uses locked_delay; delay_select changes are ignored.
    - deskewed_valid = tap valid (valid_data ignored).
    - If Deskew_error=1, go to ERROR (deskew_locked <= 0).
  - ERROR:
    - deskew_fail=1; deskewed_valid forced 0; data/block_type continue on d=0.
    - Held until Soft_RST_blocks or EN_LTSSM=0.
- Exits to reset conditions:
  - EN_LTSSM=0 in any state: next state IDLE; deskew_locked, deskew_fail and locked_delay cleared; lines not flushed.
  - Soft_RST_blocks=1 (highest priority after rst): on the next edge, flush all stages and outputs to 0 and clear locked_delay, deskew_locked and deskew_fail. Next state = TRAIN if EN_LTSSM=1, else IDLE.
- Simultaneous events, priority order: rst > Soft_RST_blocks > EN_LTSSM=0 > Deskew_error > valid_deskew.
- Delay selection rules:
  - A delay change in TRAIN takes effect on the same edge; no bubble insertion beyond valid_data masking.
  - delay_select cannot exceed DEPTH-1 by width; no saturation logic is needed.

Test Plan:
- Bypass: EN_LTSSM=0, lane0 data 0x11,0x22,0x33 -> same sequence on deskewed_RX_Data[0] exactly 1 cycle later; deskew_locked=0.
- Alignment: EN_LTSSM=1, SDS 0xE1 at cycle 0 on lane0, cycle 3 on lane1, cycle 5 on lanes 2..31. Controller delays 5/2/0, then valid_deskew -> deskew_locked=1 next edge. 0xE1 appears on all lanes on the same cycle: cycle 6.
- Lock freeze: after lock, drive delay_select[0]=7 -> lane0 latency stays 6 cycles; deskewed_valid stays 1.
- Error: Deskew_error=1 in TRAIN -> deskew_fail=1 next edge; deskewed_valid=0 on all lanes until Soft_RST_blocks pulse; then deskew_fail=0 and state TRAIN.
- Soft reset mid-LOCKED with lines full of 0xAA -> next cycle all outputs 0; deskew_locked=0; data path restarts at latency 1.
- Priority: Deskew_error and valid_deskew asserted on the same edge in TRAIN -> ERROR, deskew_locked stays 0. Async rst mid-lock -> all outputs 0 immediately, without waiting for a clock edge.
